// File: rtl/mips_instr_encoder.sv
// Assembles R/I/J field sets into 32-bit MIPS words, buffers them in program order,
// and replays the buffered program over a valid/ready stream when start is pulsed.
module mips_instr_encoder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_fmt,
    input  logic [5:0]    in_opcode,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_addr,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic [AW:0]   count,
    output logic          err
);

    localparam logic [0:0]    ST_LOAD   = 1'b0;
    localparam logic [0:0]    ST_STREAM = 1'b1;
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [0:0]    state_reg;
    logic [AW:0]   count_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [31:0]   out_data_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic          err_reg;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   enc_word;
    logic          set_legal;
    logic          accept;
    logic          wr_en;
    logic [AW:0]   count_after_wr;
    logic          start_go;
    logic          xfer;
    logic [AW-1:0] rd_next;
    logic          next_is_last;

    // Field packing and legality; opcodes 0/2/3 belong to R/J space and cannot tag an I word.
    always_comb begin
        enc_word  = 32'd0;
        set_legal = 1'b0;
        case (in_fmt)
            2'd0: begin
                enc_word  = {6'd0, in_rs, in_rt, in_rd, in_shamt, in_funct};
                set_legal = 1'b1;
            end
            2'd1: begin
                enc_word  = {in_opcode, in_rs, in_rt, in_imm};
                set_legal = !((in_opcode == 6'd0) || (in_opcode == 6'd2) || (in_opcode == 6'd3));
            end
            2'd2: begin
                enc_word  = {in_opcode, in_addr};
                set_legal = (in_opcode == 6'd2) || (in_opcode == 6'd3);
            end
            default: begin
                enc_word  = 32'd0;
                set_legal = 1'b0;
            end
        endcase
    end

    assign in_ready       = (state_reg == ST_LOAD) && (count_reg < CNT_FULL);
    assign accept         = in_valid && in_ready;
    assign wr_en          = accept && set_legal;
    assign count_after_wr = wr_en ? (count_reg + CNT_ONE) : count_reg;
    assign start_go       = (state_reg == ST_LOAD) && start && (count_after_wr != '0);
    assign xfer           = (state_reg == ST_STREAM) && out_valid_reg && out_ready;
    assign rd_next        = rd_ptr_reg + PTR_ONE;
    assign next_is_last   = ({1'b0, rd_next} == (count_reg - CNT_ONE));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_reg[AW-1:0]] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_LOAD;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            out_data_reg  <= 32'd0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= accept && !set_legal;
            case (state_reg)
                ST_LOAD: begin
                    count_reg <= count_after_wr;
                    if (start_go) begin
                        state_reg     <= ST_STREAM;
                        rd_ptr_reg    <= '0;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (count_after_wr == CNT_ONE);
                        // A word written in the start cycle at slot 0 is not yet in the array.
                        out_data_reg  <= (wr_en && (count_reg == '0)) ? enc_word : mem[0];
                    end
                end
                default: begin
                    if (xfer) begin
                        if (out_last_reg) begin
                            state_reg     <= ST_LOAD;
                            count_reg     <= '0;
                            rd_ptr_reg    <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                        end else begin
                            rd_ptr_reg   <= rd_next;
                            out_data_reg <= mem[rd_next];
                            out_last_reg <= next_is_last;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg == ST_STREAM);
    assign count     = count_reg;
    assign err       = err_reg;

endmodule
